// File: rtl/axis_master_fifo_pkt.sv
// Push-to-AXI4-Stream master FIFO: registered push credit with producer slack, tlast
// passthrough, optional store-and-forward packet mode, fill level and sticky overflow.
module axis_master_fifo_pkt #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned PUSH_SLACK  = 10,
  parameter bit          PACKET_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       push_last,
  output logic                       may_push,
  output logic                       axis_tvalid,
  input  logic                       axis_tready,
  output logic [DATA_WIDTH-1:0]      axis_tdata,
  output logic                       axis_tlast,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

  typedef enum logic {StEmpty, StValid} state_e;

  state_e              state_q;
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wptr_q, rptr_q;
  logic [LW-1:0]       level_d, pkt_cnt_q, pkt_cnt_d;
  logic                escape_q, escape_d;
  logic                pop, push_acc, pkt_inc, pkt_dec;
  logic                start_ok, cont_ok, next_avail;
  logic [AW-1:0]       rd_idx, rd_nxt;
  logic [31:0]         free_d;

  // Accept/pop decisions, next level, packet bookkeeping and output-side permissions.
  always_comb begin
    pop        = axis_tvalid & axis_tready;
    // A full FIFO still accepts when the presented entry leaves on the same edge.
    push_acc   = push & ((level != LvlFull) | pop);
    level_d    = level + LW'(push_acc) - LW'(pop);
    pkt_inc    = PACKET_MODE & push_acc & push_last;
    pkt_dec    = PACKET_MODE & pop & axis_tlast;
    pkt_cnt_d  = pkt_cnt_q + LW'(pkt_inc) - LW'(pkt_dec);
    // A new packet may start once a whole one is stored, or when full with none complete.
    start_ok   = !PACKET_MODE || (pkt_cnt_q != '0) || escape_q || (level == LvlFull);
    // After a tlast pops, the following beat opens a new packet and needs a complete one.
    cont_ok    = !PACKET_MODE || !axis_tlast || (pkt_cnt_d != '0);
    next_avail = level >= LW'(2);
    escape_d   = escape_q;
    if (pkt_dec) begin
      escape_d = 1'b0;
    end else if (PACKET_MODE && (state_q == StEmpty) && (level == LvlFull) &&
                 (pkt_cnt_q == '0)) begin
      escape_d = 1'b1;
    end
    rd_idx     = rptr_q[AW-1:0];
    rd_nxt     = rd_idx + AW'(1);
    free_d     = DEPTH - 32'(level_d);
  end

  // Pointers, level, packet counter, escape flag, credit and sticky overflow.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level     <= '0;
      pkt_cnt_q <= '0;
      escape_q  <= 1'b0;
      may_push  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_acc) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)      rptr_q <= rptr_q + (AW+1)'(1);
      level     <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      escape_q  <= escape_d;
      may_push  <= free_d > PUSH_SLACK;
      if (push && !push_acc) overflow <= 1'b1;
    end
  end

  // Storage write; the slot of the presented entry may be reused since it is already copied out.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr_q[AW-1:0]] <= {push_last, push_data};
  end

  // Output FSM: EMPTY loads the read register (EMPTY->VALID), VALID reloads on each pop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StEmpty;
      axis_tvalid <= 1'b0;
      axis_tdata  <= '0;
      axis_tlast  <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if ((level != '0) && start_ok) begin
            state_q                  <= StValid;
            axis_tvalid              <= 1'b1;
            {axis_tlast, axis_tdata} <= mem[rd_idx];
          end
        end
        StValid: begin
          if (pop) begin
            if (cont_ok && next_avail) begin
              {axis_tlast, axis_tdata} <= mem[rd_nxt];
            end else if (cont_ok && push_acc) begin
              // Only entry leaves while a new one arrives: forward it to keep 1 beat/cycle.
              {axis_tlast, axis_tdata} <= {push_last, push_data};
            end else begin
              state_q     <= StEmpty;
              axis_tvalid <= 1'b0;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_master_fifo_pkt.sv
// Bench for axis_master_fifo_pkt: cut-through instance (a_*) and packet-mode instance (b_*).
module tb_axis_master_fifo_pkt;

  localparam int unsigned DW = 16;
  localparam int unsigned DA = 16;
  localparam int unsigned SA = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned SB = 2;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic          a_push, a_last, a_may, a_tvalid, a_tready, a_tlast, a_ovf;
  logic [DW-1:0] a_data, a_tdata;
  logic [4:0]    a_level;
  logic          b_push, b_last, b_may, b_tvalid, b_tready, b_tlast, b_ovf;
  logic [DW-1:0] b_data, b_tdata;
  logic [3:0]    b_level;

  axis_master_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DA), .PUSH_SLACK(SA), .PACKET_MODE(1'b0)) u_a (
    .clk(clk), .aresetn(aresetn), .push(a_push), .push_data(a_data), .push_last(a_last),
    .may_push(a_may), .axis_tvalid(a_tvalid), .axis_tready(a_tready), .axis_tdata(a_tdata),
    .axis_tlast(a_tlast), .level(a_level), .overflow(a_ovf)
  );

  axis_master_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DB), .PUSH_SLACK(SB), .PACKET_MODE(1'b1)) u_b (
    .clk(clk), .aresetn(aresetn), .push(b_push), .push_data(b_data), .push_last(b_last),
    .may_push(b_may), .axis_tvalid(b_tvalid), .axis_tready(b_tready), .axis_tdata(b_tdata),
    .axis_tlast(b_tlast), .level(b_level), .overflow(b_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the cut-through instance: queue of stored beats plus presented flag.
  logic [DW:0] mq[$];
  bit          mvalid, movf, mmay;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit p, input logic [DW:0] beat, input bit rdy);
    int old_n;
    bit pop, acc;
    old_n = mq.size();
    pop   = mvalid && rdy;
    acc   = p && ((old_n < int'(DA)) || pop);
    if (p && !acc) movf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(beat);
    if (pop) mvalid = (mq.size() > 0);
    else if (!mvalid) mvalid = (old_n > 0);
    mmay = (int'(DA) - mq.size()) > int'(SA);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    a_push = 0; a_data = '0; a_last = 0; a_tready = 0;
    b_push = 0; b_data = '0; b_last = 0; b_tready = 0;
    step();
    step();
    checks++;
    if ({a_tvalid, a_tdata, a_tlast, a_may, a_level, a_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_a got v=%0b d=%0h l=%0b m=%0b lvl=%0d o=%0b want all 0",
               a_tvalid, a_tdata, a_tlast, a_may, a_level, a_ovf);
    end
    checks++;
    if ({b_tvalid, b_tdata, b_tlast, b_may, b_level, b_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_b got v=%0b d=%0h l=%0b m=%0b lvl=%0d o=%0b want all 0",
               b_tvalid, b_tdata, b_tlast, b_may, b_level, b_ovf);
    end
    aresetn = 1'b1;
    step();
    checks++;
    if (a_may !== 1'b1 || b_may !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_may_push got a=%0b b=%0b want 1 1", a_may, b_may);
    end
  endtask

  task automatic test_stream();
    logic [DW:0] got[$];
    logic [DW:0] exp;
    int          maxlvl;
    maxlvl   = 0;
    a_tready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      a_push = (i < 16);
      a_data = DW'(i + 1);
      a_last = (i == 15);
      step();
      if (i == 0) begin
        checks++;
        if (a_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency_edge1 tvalid got %0b want 0", a_tvalid);
        end
      end
      if (i == 1) begin
        checks++;
        if (a_tvalid !== 1'b1 || a_tdata !== DW'(1)) begin
          errors++;
          $display("FAIL stream_latency_edge2 got v=%0b d=%0d want v=1 d=1", a_tvalid, a_tdata);
        end
      end
      if (int'(a_level) > maxlvl) maxlvl = int'(a_level);
      if (a_tvalid) got.push_back({a_tlast, a_tdata});
    end
    a_push = 1'b0;
    checks++;
    if (got.size() != 16) begin
      errors++;
      $display("FAIL stream_count got %0d want 16", got.size());
    end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      exp = {(k == 15) ? 1'b1 : 1'b0, DW'(k + 1)};
      checks++;
      if (got[k] !== exp) begin
        errors++;
        $display("FAIL stream_beat%0d got %0h want %0h", k, got[k], exp);
      end
    end
    checks++;
    if (maxlvl > 2 || a_ovf !== 1'b0 || a_level !== 5'd0) begin
      errors++;
      $display("FAIL stream_level got peak=%0d ovf=%0b end=%0d want peak<=2 ovf=0 end=0",
               maxlvl, a_ovf, a_level);
    end
  endtask

  task automatic test_fill_overflow();
    logic [DW:0] got[$];
    logic [DW:0] exp;
    a_tready = 1'b0;
    a_last   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_push = 1'b1;
      a_data = DW'(100 + i);
      step();
      if (i == 10) begin
        checks++;
        if (a_may !== 1'b1) begin
          errors++;
          $display("FAIL credit_level11 may_push got %0b want 1", a_may);
        end
      end
      if (i == 11) begin
        checks++;
        if (a_may !== 1'b0 || a_level !== 5'd12) begin
          errors++;
          $display("FAIL credit_level12 got may=%0b lvl=%0d want 0 12", a_may, a_level);
        end
      end
    end
    checks++;
    if (a_level !== 5'd16 || a_ovf !== 1'b0 || a_tvalid !== 1'b1 || a_tdata !== DW'(100)) begin
      errors++;
      $display("FAIL fill16 got lvl=%0d ovf=%0b v=%0b d=%0d want 16 0 1 100",
               a_level, a_ovf, a_tvalid, a_tdata);
    end
    a_tready = 1'b1;
    a_data   = DW'(200);
    step();
    checks++;
    if (a_level !== 5'd16 || a_ovf !== 1'b0 || a_tdata !== DW'(101)) begin
      errors++;
      $display("FAIL full_push_pop got lvl=%0d ovf=%0b d=%0d want 16 0 101",
               a_level, a_ovf, a_tdata);
    end
    a_tready = 1'b0;
    a_data   = DW'(300);
    step();
    checks++;
    if (a_level !== 5'd16 || a_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drop got lvl=%0d ovf=%0b want 16 1", a_level, a_ovf);
    end
    a_push = 1'b0;
    step();
    checks++;
    if (a_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %0b want 1", a_ovf);
    end
    a_tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (a_tvalid) got.push_back({a_tlast, a_tdata});
      step();
    end
    checks++;
    if (got.size() != 16 || a_level !== 5'd0) begin
      errors++;
      $display("FAIL drain_count got %0d lvl=%0d want 16 0", got.size(), a_level);
    end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      exp = {1'b0, (k == 15) ? DW'(200) : DW'(101 + k)};
      checks++;
      if (got[k] !== exp) begin
        errors++;
        $display("FAIL drain_beat%0d got %0h want %0h", k, got[k], exp);
      end
    end
  endtask

  task automatic test_packet();
    b_tready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      b_push = 1'b1;
      b_data = DW'(50 + b);
      b_last = (b == 4);
      step();
      b_push = 1'b0;
      checks++;
      if (b_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL pkt_hold_beat%0d tvalid got %0b want 0", b, b_tvalid);
      end
      if (b < 4) begin
        for (int g = 0; g < 3; g++) begin
          step();
          checks++;
          if (b_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pkt_hold_gap%0d_%0d tvalid got %0b want 0", b, g, b_tvalid);
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (b_tvalid !== 1'b1 || b_tdata !== DW'(50 + k) || b_tlast !== (k == 4)) begin
        errors++;
        $display("FAIL pkt_stream%0d got v=%0b d=%0d l=%0b want 1 %0d %0b",
                 k, b_tvalid, b_tdata, b_tlast, 50 + k, (k == 4));
      end
    end
    step();
    checks++;
    if (b_tvalid !== 1'b0 || b_level !== 4'd0) begin
      errors++;
      $display("FAIL pkt_end got v=%0b lvl=%0d want 0 0", b_tvalid, b_level);
    end
  endtask

  task automatic test_escape();
    logic [DW-1:0] got[$];
    b_tready = 1'b1;
    b_last   = 1'b0;
    for (int b = 0; b < 8; b++) begin
      b_push = 1'b1;
      b_data = DW'(70 + b);
      step();
      checks++;
      if (b_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL escape_hold%0d tvalid got %0b want 0", b, b_tvalid);
      end
    end
    b_push = 1'b0;
    for (int c = 0; c < 30 && got.size() < 8; c++) begin
      step();
      if (b_tvalid) got.push_back(b_tdata);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL escape_drain got %0d beats want 8", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== DW'(70 + k)) begin
        errors++;
        $display("FAIL escape_beat%0d got %0d want %0d", k, got[k], 70 + k);
      end
    end
    step();
    checks++;
    if (b_tvalid !== 1'b0 || b_level !== 4'd0 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL escape_end got v=%0b lvl=%0d ovf=%0b want 0 0 0", b_tvalid, b_level, b_ovf);
    end
  endtask

  task automatic test_random();
    bit hist[$];
    int pushes;
    int cyc;
    bit p, done;
    for (int ph = 0; ph < 2; ph++) begin
      aresetn  = 1'b0;
      a_push   = 1'b0;
      a_tready = 1'b0;
      #2;
      checks++;
      if (a_tvalid !== 1'b0 || a_level !== 5'd0 || a_tdata !== '0) begin
        errors++;
        $display("FAIL rand_reset%0d got v=%0b lvl=%0d d=%0h want 0 0 0",
                 ph, a_tvalid, a_level, a_tdata);
      end
      mq.delete();
      mvalid = 1'b0;
      movf   = 1'b0;
      mmay   = 1'b0;
      hist.delete();
      for (int i = 0; i <= int'(SA); i++) hist.push_back(1'b0);
      step();
      aresetn = 1'b1;
      pushes  = 0;
      cyc     = 0;
      done    = 1'b0;
      while (!done && cyc < 4000) begin
        p        = hist[SA] && (pushes < 100) && ($urandom_range(0, 3) != 0);
        a_push   = p;
        a_data   = DW'($urandom);
        a_last   = ($urandom_range(0, 4) == 0);
        a_tready = (pushes >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
        @(posedge clk);
        model_edge(p, {a_last, a_data}, a_tready);
        #1;
        if (p) pushes++;
        cyc++;
        checks++;
        if (a_tvalid !== mvalid || (mvalid && ({a_tlast, a_tdata} !== mq[0]))) begin
          errors++;
          $display("FAIL rand_out ph%0d cyc%0d got v=%0b %0h want v=%0b %0h", ph, cyc,
                   a_tvalid, {a_tlast, a_tdata}, mvalid, mvalid ? mq[0] : '0);
        end
        checks++;
        if (a_level !== 5'(mq.size()) || a_may !== mmay || a_ovf !== movf || a_ovf !== 1'b0) begin
          errors++;
          $display("FAIL rand_state ph%0d cyc%0d got lvl=%0d may=%0b ovf=%0b want %0d %0b 0",
                   ph, cyc, a_level, a_may, a_ovf, mq.size(), mmay);
        end
        hist.push_front(a_may);
        void'(hist.pop_back());
        done = (pushes >= 100) && (ph == 0 || (mq.size() == 0 && !mvalid));
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL rand_progress ph%0d got %0d pushes, left=%0d want 100 pushes drained",
                 ph, pushes, mq.size());
      end
      a_push = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_overflow();
    test_packet();
    test_escape();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
